// File: rtl/pong_text_pkg.sv
// Shared constants, FSM encoding and character helpers for the on-screen score text.
package pong_text_pkg;

    localparam logic [6:0] CHAR_SPACE = 7'h20;
    localparam logic [6:0] CHAR_ZERO  = 7'h30;
    localparam int         DIGITS     = 3;
    localparam int         BCD_W      = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT_L = 2'd1,
        ST_SHIFT_R = 2'd2,
        ST_COMMIT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [6:0] c2;
        logic [6:0] c1;
        logic [6:0] c0;
    } chars_t;

    // Hundreds/tens/ones BCD to ASCII, optionally blanking leading zeros (ones never blank).
    function automatic chars_t bcd_to_chars(input logic [BCD_W-1:0] bcd, input logic blank_lz);
        chars_t ch;
        logic   h_zero;
        logic   t_zero;
        h_zero = (bcd[11:8] == 4'd0);
        t_zero = (bcd[7:4] == 4'd0);
        ch.c2  = (blank_lz && h_zero) ? CHAR_SPACE : CHAR_ZERO + {3'b000, bcd[11:8]};
        ch.c1  = (blank_lz && h_zero && t_zero) ? CHAR_SPACE : CHAR_ZERO + {3'b000, bcd[7:4]};
        ch.c0  = CHAR_ZERO + {3'b000, bcd[3:0]};
        return ch;
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift in one binary bit.
module bcd_dd_step
    import pong_text_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    input  logic             bit_i,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BCD_W-1:0] adj;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end
        end
        // Scores never exceed 999, so the bit shifted out of the top is always zero.
        bcd_o = BCD_W'({adj, bit_i});
    end

endmodule

// File: rtl/score_ascii_conv.sv
// Snapshots both player scores on frame_start, converts them to BCD serially and
// commits all six ASCII characters in a single cycle.
module score_ascii_conv
    import pong_text_pkg::*;
#(
    parameter int SCORE_W  = 7,
    parameter int BLANK_LZ = 1
) (
    input  logic               clk_0,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [SCORE_W-1:0] score_l,
    input  logic [SCORE_W-1:0] score_r,
    output logic [6:0]         l_char2,
    output logic [6:0]         l_char1,
    output logic [6:0]         l_char0,
    output logic [6:0]         r_char2,
    output logic [6:0]         r_char1,
    output logic [6:0]         r_char0,
    output logic               busy,
    output logic               valid
);

    localparam logic             BLANK     = (BLANK_LZ != 0);
    localparam int               CNT_W     = 4;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SCORE_W - 1);
    localparam chars_t           RST_CHARS = bcd_to_chars('0, BLANK);

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [SCORE_W-1:0] snap_l_q,   snap_l_d;
    logic [SCORE_W-1:0] snap_r_q,   snap_r_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic [BCD_W-1:0]   left_bcd_q, left_bcd_d;
    chars_t             l_chars_q,  l_chars_d;
    chars_t             r_chars_q,  r_chars_d;
    logic               valid_q,    valid_d;

    logic               step_bit;
    logic [BCD_W-1:0]   step_out;

    // A single converter step is time-shared between the left and right phases.
    bcd_dd_step u_step (
        .bcd_i (bcd_q),
        .bit_i (step_bit),
        .bcd_o (step_out)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_l_d   = snap_l_q;
        snap_r_d   = snap_r_q;
        bcd_d      = bcd_q;
        left_bcd_d = left_bcd_q;
        l_chars_d  = l_chars_q;
        r_chars_d  = r_chars_q;
        valid_d    = 1'b0;
        step_bit   = (state_q == ST_SHIFT_R) ? snap_r_q[SCORE_W-1] : snap_l_q[SCORE_W-1];

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    snap_l_d = score_l;
                    snap_r_d = score_r;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT_L;
                end
            end
            ST_SHIFT_L: begin
                bcd_d    = step_out;
                snap_l_d = snap_l_q << 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    left_bcd_d = step_out;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = ST_SHIFT_R;
                end
            end
            ST_SHIFT_R: begin
                bcd_d    = step_out;
                snap_r_d = snap_r_q << 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // The right result is still in the accumulator; both sides land together.
                l_chars_d = bcd_to_chars(left_bcd_q, BLANK);
                r_chars_d = bcd_to_chars(bcd_q, BLANK);
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            snap_l_q   <= '0;
            snap_r_q   <= '0;
            bcd_q      <= '0;
            left_bcd_q <= '0;
            l_chars_q  <= RST_CHARS;
            r_chars_q  <= RST_CHARS;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_l_q   <= snap_l_d;
            snap_r_q   <= snap_r_d;
            bcd_q      <= bcd_d;
            left_bcd_q <= left_bcd_d;
            l_chars_q  <= l_chars_d;
            r_chars_q  <= r_chars_d;
            valid_q    <= valid_d;
        end
    end

    assign l_char2 = l_chars_q.c2;
    assign l_char1 = l_chars_q.c1;
    assign l_char0 = l_chars_q.c0;
    assign r_char2 = r_chars_q.c2;
    assign r_char1 = r_chars_q.c1;
    assign r_char0 = r_chars_q.c0;
    assign busy    = (state_q != ST_IDLE);
    assign valid   = valid_q;

endmodule

// File: doc/score_ascii_conv.md
# score_ascii_conv

Converts the two binary player scores into ASCII digit codes for the on-screen score readout. It sits directly upstream of the per-character glyph renderers and drives their 7-bit `char_code` inputs. It snapshots both scores on a frame-start pulse and runs a sequential double-dabble binary-to-BCD conversion, one bit per cycle, left score then right score. All six character outputs then update in a single cycle, so a frame never shows a half-updated score.

## Interface
Parameters:
- `SCORE_W`, default 7: score width in bits; legal range 1–9, so three decimal digits always suffice.
- `BLANK_LZ`, default 1: 1 replaces leading zeros with ASCII space; 0 shows all three digits.

Ports:
- `clk_0`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking.
- `score_l`  in  SCORE_W  left player score, unsigned.
- `score_r`  in  SCORE_W  right player score, unsigned.
- `l_char2`, `l_char1`, `l_char0`  out  7 each  left score ASCII, hundreds/tens/ones.
- `r_char2`, `r_char1`, `r_char0`  out  7 each  right score ASCII, hundreds/tens/ones.
- `busy`  out  1  high while a conversion is in progress.
- `valid`  out  1  one-cycle pulse when new characters are committed.

## Operation
- FSM states: IDLE, SHIFT_L, SHIFT_R, COMMIT.
- **IDLE**
  - On `frame_start`=1, snapshot `score_l` and `score_r` into shift registers.
  - Clear the 12-bit BCD accumulator and the bit counter.
  - Go to SHIFT_L.
- **SHIFT_L**, one double-dabble iteration per cycle:
  - Each BCD nibble ≥5 gets +3.
  - Then shift {BCD, snapshot} left by 1, MSB of the snapshot entering BCD bit 0.
  - After SCORE_W iterations, store the left BCD result, clear the accumulator, go to SHIFT_R.
- **SHIFT_R**: same iteration on the right snapshot. After SCORE_W iterations, go to COMMIT.
- **COMMIT**
  - Register all six outputs together.
  - Pulse `valid`=1 for exactly one cycle.
  - Go to IDLE.
- Digit encoding: char = 0x30 + BCD digit.
- Leading-zero blanking, when `BLANK_LZ`=1:
  - hundreds=0 → 0x20 (space).
  - hundreds=0 and tens=0 → tens also 0x20.
  - Ones is never blanked.
- `busy` = (state != IDLE).
- `frame_start` while `busy` is ignored. It is not queued; the next conversion waits for the next pulse.
- Input changes after the snapshot edge have no effect on the conversion in progress.
- Outputs hold their last committed value at all times outside COMMIT.

## Timing
- Snapshot happens at the clock edge E0 that samples `frame_start`=1 in IDLE.
- Outputs and `valid` update at edge E0+2·SCORE_W+1. For SCORE_W=7 this is 15 cycles, far inside vertical blanking.
- `busy` rises after E0 and falls after the COMMIT edge. `valid` and the new characters appear in the same cycle.
- Reset values, held immediately and asynchronously on `rst`=0:
  - With `BLANK_LZ`=1: `l_char2`=`l_char1`=`r_char2`=`r_char1`=0x20.
  - With `BLANK_LZ`=0: those four are 0x30.
  - `l_char0`=`r_char0`=0x30.
  - `busy`=0, `valid`=0, FSM in IDLE.
- Reset during SHIFT_L, SHIFT_R or COMMIT aborts the conversion. No partial result is ever committed.
- Release of reset resumes in IDLE; the first conversion needs a new `frame_start`.

## Structure
- Shared package `pong_text_pkg`:
  - `CHAR_SPACE` = 7'h20, `CHAR_ZERO` = 7'h30.
  - FSM state encoding, 2 bits.
  - `DIGITS` = 3.
- Sub-module `bcd_dd_step`: combinational, 12-bit BCD plus 1 input bit → 12-bit corrected and shifted BCD. It is instantiated once and shared by both phases.
- Sequential logic stays in `score_ascii_conv`: FSM, bit counter, snapshots, left-result holding register, output registers.

## Test plan
- After reset, with `BLANK_LZ`=1: outputs read "  0" / "  0" (0x20,0x20,0x30 each side); `busy`=0; `valid`=0.
- `score_l`=0, `score_r`=127, pulse `frame_start`:
  - left = 0x20,0x20,0x30; right = 0x31,0x32,0x37.
  - `valid` pulses exactly 15 cycles after the sampling edge.
- `score_l`=5, `score_r`=40: left "  5", right " 40" (0x20,0x34,0x30). With `BLANK_LZ`=0 the same scores give "005" and "040".
- Pulse `frame_start`, then change scores and pulse `frame_start` again at cycle 6:
  - Result reflects the first snapshot only.
  - Exactly one `valid` pulse; outputs unchanged until a later pulse.
- Assert `rst` low at cycle 10 of a conversion of 99/99: outputs return immediately to reset values and `valid` never pulses.
- Sweep all 128 × 128 score pairs at SCORE_W=7 against a reference model. Check the outputs only change on `valid` cycles.
